car_motion_ctrl: RTL and testbench

Car-side motion and door controller for one elevator car. It is the responder to the dispatcher's per-car `stop_next`/`continue` controls, and it drives the `inc`/`dec` arrival pulses back to the dispatcher. Car motion uses deterministic travel and door-dwell counters instead of nondeterministic stalls, so the car closes the protocol loop with bounded, checkable latency. One instance is built per car, beside the dispatcher.

---
 rtl/car_motion_ctrl.sv | 252 +++++++++++++++++++++++++
 tb/tb_car_motion_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/car_motion_ctrl.sv
// -----------------------------------------------------------------------------
// car_motion_ctrl
//   Car-side motion and door controller for one elevator car. Answers the
//   dispatcher's stop_next / continue requests and reports each single-floor
//   arrival with a one-cycle inc (up) or dec (down) pulse. Travel and door
//   dwell times are fixed down-counts, so all latencies are deterministic.
//
// Parameters
//   FLOORS      number of floors (>= 2), numbered 0..FLOORS-1
//   FW          floor-number width, ceil(log2(FLOORS))
//   TRAVEL_CYC  cycles spent in MOVING per floor (>= 1)
//   DOOR_CYC    cycles spent in each of OPENING, OPEN, CLOSING (>= 1)
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   init_floor   floor loaded while in reset (clamped to FLOORS-1)
//   stop_next    request a stop at the next floor in the current direction
//   continue_req request to keep travelling (the dispatcher's "continue";
//                renamed because continue is a reserved word)
//   car_call     in-car button pushes, level-sampled
//   inc / dec    one-cycle arrival pulse, one floor up / down
//   location     current floor
//   direction    0 = UP, 1 = DOWN
//   door_open    high in OPENING, OPEN and CLOSING
//   moving       high in MOVING
//   car_buttons  pending in-car stop requests
//
// Build option
//   CAR_DOOR_REOPEN_EN  when defined, car_call[location] during CLOSING
//                       reopens the door on the next edge; otherwise the
//                       close completes and IDLE reopens from the latch.
// -----------------------------------------------------------------------------
module car_motion_ctrl #(
   parameter int unsigned FLOORS     = 3,
   parameter int unsigned FW         = 2,
   parameter int unsigned TRAVEL_CYC = 4,
   parameter int unsigned DOOR_CYC   = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [FW-1:0]     init_floor,
   input  logic              stop_next,
   input  logic              continue_req,
   input  logic [FLOORS-1:0] car_call,
   output logic              inc,
   output logic              dec,
   output logic [FW-1:0]     location,
   output logic              direction,
   output logic              door_open,
   output logic              moving,
   output logic [FLOORS-1:0] car_buttons
);

   localparam int unsigned TMAX = (TRAVEL_CYC > DOOR_CYC) ? TRAVEL_CYC : DOOR_CYC;
   localparam int unsigned TW   = $clog2(TMAX + 1);

   localparam logic [TW-1:0] T_DOOR   = TW'(DOOR_CYC);
   localparam logic [TW-1:0] T_TRAVEL = TW'(TRAVEL_CYC);
   localparam logic [TW-1:0] T_ONE    = TW'(1);
   localparam logic [FW-1:0] TOP      = FW'(FLOORS - 1);

   localparam logic DIR_UP = 1'b0;
   localparam logic DIR_DN = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_OPENING,
      ST_OPEN,
      ST_CLOSING,
      ST_MOVING
   } state_e;

   state_e            state_q, state_d;
   logic [TW-1:0]     tmr_q, tmr_d;
   logic [FW-1:0]     location_q, location_d;
   logic              direction_q, direction_d;
   logic [FLOORS-1:0] car_buttons_q, car_buttons_d;

   logic [FW-1:0]     init_loc;
   logic              at_top, at_bot;
   logic              dir_eff;
   logic              req_above, req_below;
   logic              req_ahead, req_behind;
   logic              cont_ok;

   // Out-of-range starting floors park the car at the top floor.
   always_comb begin
      init_loc = init_floor;
      if (32'(init_floor) >= FLOORS) begin
         init_loc = TOP;
      end
   end

   always_comb begin
      at_top = (location_q == TOP);
      at_bot = (location_q == '0);
   end

   // Pending requests strictly above / below the current floor.
   always_comb begin
      req_above = 1'b0;
      req_below = 1'b0;
      for (int unsigned j = 0; j < FLOORS; j++) begin
         if (car_buttons_q[j]) begin
            if (j > 32'(location_q)) req_above = 1'b1;
            if (j < 32'(location_q)) req_below = 1'b1;
         end
      end
   end

   // In IDLE the direction is pinned at the end floors; ahead/behind are
   // judged against that pinned value so a boundary car never tries to
   // leave the shaft.
   always_comb begin
      dir_eff = direction_q;
      if (at_top) begin
         dir_eff = DIR_DN;
      end else if (at_bot) begin
         dir_eff = DIR_UP;
      end
      req_ahead  = (dir_eff == DIR_UP) ? req_above : req_below;
      req_behind = (dir_eff == DIR_UP) ? req_below : req_above;
      // continue only counts between the end floors
      cont_ok    = continue_req && !at_top && !at_bot;
   end

   always_comb begin
      state_d       = state_q;
      tmr_d         = tmr_q;
      location_d    = location_q;
      direction_d   = direction_q;
      car_buttons_d = car_buttons_q | car_call;
      inc           = 1'b0;
      dec           = 1'b0;

      case (state_q)
         ST_IDLE: begin
            direction_d = dir_eff;
            tmr_d       = T_DOOR;
            if (car_buttons_q[location_q]) begin
               state_d = ST_OPENING;
               tmr_d   = T_DOOR;
            end else if (req_ahead || cont_ok) begin
               state_d = ST_MOVING;
               tmr_d   = T_TRAVEL;
            end else if (req_behind) begin
               direction_d = ~dir_eff;
            end
         end

         ST_OPENING: begin
            car_buttons_d[location_q] = 1'b0;
            if (tmr_q == T_ONE) begin
               state_d = ST_OPEN;
               tmr_d   = T_DOOR;
            end else begin
               tmr_d = tmr_q - T_ONE;
            end
         end

         ST_OPEN: begin
            car_buttons_d[location_q] = 1'b0;
            if (tmr_q == T_ONE) begin
               state_d = ST_CLOSING;
               tmr_d   = T_DOOR;
            end else begin
               tmr_d = tmr_q - T_ONE;
            end
         end

         ST_CLOSING: begin
`ifdef CAR_DOOR_REOPEN_EN
            if (car_call[location_q]) begin
               state_d = ST_OPENING;
               tmr_d   = T_DOOR;
            end else if (tmr_q == T_ONE) begin
               state_d = ST_IDLE;
               tmr_d   = T_DOOR;
            end else begin
               tmr_d = tmr_q - T_ONE;
            end
`else
            if (tmr_q == T_ONE) begin
               state_d = ST_IDLE;
               tmr_d   = T_DOOR;
            end else begin
               tmr_d = tmr_q - T_ONE;
            end
`endif
         end

         ST_MOVING: begin
            if (tmr_q == T_ONE) begin
               state_d = ST_IDLE;
               tmr_d   = T_DOOR;
               // Range guard: a step off either end is never reported.
               if (direction_q == DIR_UP && !at_top) begin
                  inc        = 1'b1;
                  location_d = location_q + FW'(1);
               end else if (direction_q == DIR_DN && !at_bot) begin
                  dec        = 1'b1;
                  location_d = location_q - FW'(1);
               end
            end else begin
               tmr_d = tmr_q - T_ONE;
            end
         end

         default: begin
            state_d = ST_IDLE;
            tmr_d   = T_DOOR;
         end
      endcase

      // Applied after the door clear so it wins; it can never target the
      // current floor, so the two never fight over the same bit.
      if (stop_next) begin
         if (direction_q == DIR_UP && !at_top) begin
            car_buttons_d[location_q + FW'(1)] = 1'b1;
         end else if (direction_q == DIR_DN && !at_bot) begin
            car_buttons_d[location_q - FW'(1)] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_OPEN;
         tmr_q         <= T_DOOR;
         location_q    <= init_loc;
         direction_q   <= DIR_UP;
         car_buttons_q <= '0;
      end else begin
         state_q       <= state_d;
         tmr_q         <= tmr_d;
         location_q    <= location_d;
         direction_q   <= direction_d;
         car_buttons_q <= car_buttons_d;
      end
   end

   always_comb begin
      location    = location_q;
      direction   = direction_q;
      car_buttons = car_buttons_q;
      moving      = (state_q == ST_MOVING);
      door_open   = (state_q == ST_OPENING) || (state_q == ST_OPEN) ||
                    (state_q == ST_CLOSING);
   end

endmodule

// File: tb/tb_car_motion_ctrl.sv
// -----------------------------------------------------------------------------
// tb_car_motion_ctrl
//   Directed bench for car_motion_ctrl with FLOORS=3, TRAVEL_CYC=4,
//   DOOR_CYC=3. Inputs change 1 time unit after a rising edge and outputs
//   are sampled at the same point, so every step() shows the state just
//   after one edge. Expected values are hand-derived cycle counts.
// -----------------------------------------------------------------------------
module tb_car_motion_ctrl;

   logic       clk;
   logic       rst_n;
   logic [1:0] init_floor;
   logic       stop_next;
   logic       continue_req;
   logic [2:0] car_call;
   logic       inc;
   logic       dec;
   logic [1:0] location;
   logic       direction;
   logic       door_open;
   logic       moving;
   logic [2:0] car_buttons;

   int n_vec = 0;
   int n_err = 0;

`ifdef CAR_DOOR_REOPEN_EN
   localparam logic REOPEN = 1'b1;
`else
   localparam logic REOPEN = 1'b0;
`endif

   car_motion_ctrl #(
      .FLOORS    (3),
      .FW        (2),
      .TRAVEL_CYC(4),
      .DOOR_CYC  (3)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .init_floor  (init_floor),
      .stop_next   (stop_next),
      .continue_req(continue_req),
      .car_call    (car_call),
      .inc         (inc),
      .dec         (dec),
      .location    (location),
      .direction   (direction),
      .door_open   (door_open),
      .moving      (moving),
      .car_buttons (car_buttons)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [1:0] fl);
      rst_n        = 1'b0;
      init_floor   = fl;
      car_call     = '0;
      stop_next    = 1'b0;
      continue_req = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      repeat (6) step();
   endtask

   task automatic wait_idle(input string tag);
      int unsigned n = 0;
      while ((door_open || moving) && n < 40) begin
         step();
         n++;
      end
      check(tag, 32'(door_open | moving), 32'(0));
   endtask

   initial begin
      rst_n        = 1'b0;
      init_floor   = 2'd1;
      stop_next    = 1'b0;
      continue_req = 1'b0;
      car_call     = '0;

      // ---- reset values and door cycle out of reset ----
      step();
      step();
      check("rst_location", 32'(location), 32'(1));
      check("rst_door_open", 32'(door_open), 32'(1));
      check("rst_direction", 32'(direction), 32'(0));
      check("rst_incdec", 32'({inc, dec}), 32'(0));
      check("rst_moving", 32'(moving), 32'(0));
      check("rst_buttons", 32'(car_buttons), 32'(0));
      rst_n = 1'b1;
      repeat (5) step();
      check("rst_still_closing", 32'(door_open), 32'(1));
      step();
      check("rst_idle_door", 32'(door_open), 32'(0));
      check("rst_idle_moving", 32'(moving), 32'(0));
      check("rst_idle_location", 32'(location), 32'(1));

      // ---- out-of-range init_floor clamps to top ----
      rst_n      = 1'b0;
      init_floor = 2'd3;
      step();
      check("clamp_location", 32'(location), 32'(2));

      // ---- two-floor trip 0 -> 2 ----
      do_reset(2'd0);
      car_call = 3'b100;
      step();
      check("trip_btn_latched", 32'(car_buttons), 32'(3'b100));
      check("trip_not_moving", 32'(moving), 32'(0));
      car_call = '0;
      step();
      check("trip_moving", 32'(moving), 32'(1));
      check("trip_no_inc_start", 32'(inc), 32'(0));
      step();
      step();
      check("trip_inc_early", 32'(inc), 32'(0));
      step();
      check("trip_inc1", 32'(inc), 32'(1));
      check("trip_dec1", 32'(dec), 32'(0));
      check("trip_loc_before", 32'(location), 32'(0));
      step();
      check("trip_loc1", 32'(location), 32'(1));
      check("trip_inc1_width", 32'(inc), 32'(0));
      check("trip_idle1", 32'(moving), 32'(0));
      step();
      check("trip_moving2", 32'(moving), 32'(1));
      repeat (3) step();
      check("trip_inc2", 32'(inc), 32'(1));
      step();
      check("trip_loc2", 32'(location), 32'(2));
      step();
      check("trip_opening", 32'(door_open), 32'(1));
      check("trip_dir_top", 32'(direction), 32'(1));
      check("trip_btn_pending", 32'(car_buttons), 32'(3'b100));
      step();
      check("trip_btn_cleared", 32'(car_buttons), 32'(0));
      wait_idle("trip_idle_end");

      // ---- top boundary: continue ignored, then go down to 0 ----
      continue_req = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         check("top_no_inc", 32'(inc), 32'(0));
         check("top_no_move", 32'(moving), 32'(0));
      end
      continue_req = 1'b0;
      check("top_dir_down", 32'(direction), 32'(1));
      car_call = 3'b001;
      step();
      car_call = '0;
      step();
      check("down_moving", 32'(moving), 32'(1));
      repeat (3) step();
      check("down_dec1", 32'(dec), 32'(1));
      check("down_no_inc1", 32'(inc), 32'(0));
      step();
      check("down_loc1", 32'(location), 32'(1));
      check("down_dec1_width", 32'(dec), 32'(0));
      step();
      repeat (3) step();
      check("down_dec2", 32'(dec), 32'(1));
      step();
      check("down_loc0", 32'(location), 32'(0));
      step();
      check("down_opening", 32'(door_open), 32'(1));
      check("down_dir_up", 32'(direction), 32'(0));
      wait_idle("down_idle_end");

      // ---- stop_next during MOVING up from floor 0 ----
      car_call = 3'b100;
      step();
      car_call = '0;
      step();
      check("stop_moving", 32'(moving), 32'(1));
      stop_next = 1'b1;
      step();
      stop_next = 1'b0;
      check("stop_btn_set", 32'(car_buttons), 32'(3'b110));
      step();
      step();
      check("stop_inc", 32'(inc), 32'(1));
      step();
      check("stop_loc1", 32'(location), 32'(1));
      step();
      check("stop_opening", 32'(door_open), 32'(1));
      check("stop_opening_still", 32'(moving), 32'(0));
      step();
      check("stop_btn_cleared", 32'(car_buttons), 32'(3'b100));

      // ---- door reopen from car_call in 2nd CLOSING cycle ----
      rst_n      = 1'b0;
      init_floor = 2'd1;
      car_call   = '0;
      step();
      step();
      rst_n = 1'b1;
      repeat (4) step();
      check("reopen_closing", 32'(door_open), 32'(1));
      car_call = 3'b010;
      step();
      car_call = '0;
      check("reopen_btn", 32'(car_buttons), 32'(3'b010));
      step();
      check("reopen_door_e6", 32'(door_open), 32'(REOPEN));
      step();
      check("reopen_door_e7", 32'(door_open), 32'(1));
      check("reopen_btn_e7", 32'(car_buttons), REOPEN ? 32'(0) : 32'(3'b010));
      step();
      check("reopen_btn_e8", 32'(car_buttons), 32'(0));
      check("reopen_door_e8", 32'(door_open), 32'(1));

      // ---- reset asserted while the arrival pulse is high ----
      do_reset(2'd0);
      car_call = 3'b010;
      step();
      car_call = '0;
      step();
      repeat (3) step();
      check("rmid_inc_pending", 32'(inc), 32'(1));
      init_floor = 2'd2;
      rst_n      = 1'b0;
      #1;
      check("rmid_inc_dropped", 32'(inc), 32'(0));
      check("rmid_location", 32'(location), 32'(2));
      check("rmid_moving", 32'(moving), 32'(0));
      check("rmid_door_open", 32'(door_open), 32'(1));
      step();
      rst_n = 1'b1;
      step();
      check("rmid_after_loc", 32'(location), 32'(2));
      check("rmid_after_incdec", 32'({inc, dec}), 32'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
